// File: rtl/pg_port_quiesce_pkg.sv
// Shared types and constants for the per-port reset quiesce sequencer.
package pg_port_quiesce_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    ASSERT  = 2'd2,
    RELEASE = 2'd3
  } t_quiesce_state;

  localparam int unsigned DEF_RST_HOLD_CYCLES = 32'd16;
  localparam int unsigned DEF_RST_PIPE_DEPTH  = 32'd4;
  localparam int unsigned DEF_DRAIN_TIMEOUT   = 32'd4096;

  // One counter is shared by hold, release and drain-timeout phases.
  function automatic int unsigned cnt_width(input int unsigned hold,
                                            input int unsigned pipe,
                                            input int unsigned tmo);
    int unsigned m;
    m = hold;
    if (pipe > m) m = pipe;
    else          m = m;
    if (tmo > m)  m = tmo;
    else          m = m;
    return $clog2(m + 32'd1);
  endfunction

endpackage

// File: rtl/pg_port_quiesce_fsm.sv
// Single-port quiesce FSM: blocks new packets, drains, holds reset, then releases.
// Optional drain timeout enabled by defining PG_QUIESCE_TIMEOUT_EN.
module pg_port_quiesce_fsm
  import pg_port_quiesce_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int unsigned RST_PIPE_DEPTH  = DEF_RST_PIPE_DEPTH,
  parameter int unsigned DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_n,
  input  logic tvalid,
  input  logic tready,
  input  logic tlast,
  output logic tx_block,
  output logic port_rst_n,
  output logic port_rst_ack,
  output logic drain_timeout
);

  localparam int unsigned CW = cnt_width(RST_HOLD_CYCLES, RST_PIPE_DEPTH, DRAIN_TIMEOUT);
  localparam logic [CW-1:0] HOLD_LD  = CW'(RST_HOLD_CYCLES - 32'd1);
  localparam logic [CW-1:0] PIPE_LD  = CW'(RST_PIPE_DEPTH - 32'd1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

  t_quiesce_state state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           in_pkt_q, in_pkt_d, in_pkt_nx, beat;
  logic           tx_block_q, tx_block_d;
  logic           rst_n_q, rst_n_d;
  logic           ack_q, ack_d;

  assign beat = tvalid & tready;

  // Packet tracking runs in every state so reset never lands mid-packet.
  always_comb begin
    if (beat) in_pkt_nx = ~tlast;
    else      in_pkt_nx = in_pkt_q;
  end

`ifdef PG_QUIESCE_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LD = CW'(DRAIN_TIMEOUT - 32'd1);
  logic tmo_q, tmo_d;

  // Sticky timeout flag, only cleared by the global reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= 1'b0;
    else        tmo_q <= tmo_d;
  end
  assign drain_timeout = tmo_q;
`else
  assign drain_timeout = 1'b0;
`endif

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ASSERT;
      cnt_q      <= HOLD_LD;
      in_pkt_q   <= 1'b0;
      tx_block_q <= 1'b1;
      rst_n_q    <= 1'b0;
      ack_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_pkt_q   <= in_pkt_d;
      tx_block_q <= tx_block_d;
      rst_n_q    <= rst_n_d;
      ack_q      <= ack_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_pkt_d = in_pkt_nx;
`ifdef PG_QUIESCE_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      RUN: begin
        if (!req_n) begin
          state_d = DRAIN;
`ifdef PG_QUIESCE_TIMEOUT_EN
          cnt_d   = TMO_LD;
`endif
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (!in_pkt_nx) begin
          state_d = ASSERT;
          cnt_d   = HOLD_LD;
`ifdef PG_QUIESCE_TIMEOUT_EN
        end else if (cnt_q == CNT_ZERO) begin
          state_d  = ASSERT;
          cnt_d    = HOLD_LD;
          in_pkt_d = 1'b0;
          tmo_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
`else
        end else begin
          state_d = DRAIN;
`endif
        end
      end
      ASSERT: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (req_n) begin
          state_d = RELEASE;
          cnt_d   = PIPE_LD;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      RELEASE: begin
        if (!req_n) begin
          state_d = ASSERT;
          cnt_d   = HOLD_LD;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = HOLD_LD;
      end
    endcase
  end

  // Output decode; reset deasserts one cycle after RUN is entered (final release stage).
  always_comb begin
    tx_block_d = (state_d != RUN);
    rst_n_d    = (state_d == DRAIN) || ((state_d == RUN) && (state_q == RUN));
    ack_d      = (state_d == ASSERT);
  end

  assign tx_block     = tx_block_q;
  assign port_rst_n   = rst_n_q;
  assign port_rst_ack = ack_q;

endmodule

// File: rtl/pg_port_rst_quiesce.sv
// Packet-aware port reset sequencer covering all flattened ports.
// Optional drain timeout enabled by defining PG_QUIESCE_TIMEOUT_EN.
module pg_port_rst_quiesce
  import pg_port_quiesce_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 32'd4,
  parameter int unsigned RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int unsigned RST_PIPE_DEPTH  = DEF_RST_PIPE_DEPTH,
  parameter int unsigned DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] port_rst_req_n,
  input  logic [NUM_PORTS-1:0] tx_tvalid,
  input  logic [NUM_PORTS-1:0] tx_tready,
  input  logic [NUM_PORTS-1:0] tx_tlast,
  output logic [NUM_PORTS-1:0] tx_block,
  output logic [NUM_PORTS-1:0] port_rst_n_out,
  output logic [NUM_PORTS-1:0] port_rst_ack,
  output logic [NUM_PORTS-1:0] drain_timeout
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    pg_port_quiesce_fsm #(
      .RST_HOLD_CYCLES (RST_HOLD_CYCLES),
      .RST_PIPE_DEPTH  (RST_PIPE_DEPTH),
      .DRAIN_TIMEOUT   (DRAIN_TIMEOUT)
    ) u_fsm (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_n         (port_rst_req_n[p]),
      .tvalid        (tx_tvalid[p]),
      .tready        (tx_tready[p]),
      .tlast         (tx_tlast[p]),
      .tx_block      (tx_block[p]),
      .port_rst_n    (port_rst_n_out[p]),
      .port_rst_ack  (port_rst_ack[p]),
      .drain_timeout (drain_timeout[p])
    );
  end

endmodule

// File: tb/tb_pg_port_rst_quiesce.sv
// Scoreboard bench for pg_port_rst_quiesce: expectations queued with a target cycle.
module tb_pg_port_rst_quiesce;

  localparam int F_RST = 0;
  localparam int F_BLK = 1;
  localparam int F_ACK = 2;
  localparam int F_TO  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_n, tvalid, tready, tlast;
  logic [3:0] tx_block, port_rst_n_out, port_rst_ack, drain_timeout;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;
  int t;

  typedef struct {
    string tag;
    int    at;
    int    port;
    int    fld;
    logic  exp;
  } sb_t;
  sb_t sb[$];

  pg_port_rst_quiesce #(
    .NUM_PORTS       (4),
    .RST_HOLD_CYCLES (16),
    .RST_PIPE_DEPTH  (4),
    .DRAIN_TIMEOUT   (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .port_rst_req_n (req_n),
    .tx_tvalid      (tvalid),
    .tx_tready      (tready),
    .tx_tlast       (tlast),
    .tx_block       (tx_block),
    .port_rst_n_out (port_rst_n_out),
    .port_rst_ack   (port_rst_ack),
    .drain_timeout  (drain_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int at, input int port, input int fld, input logic e);
    sb_t x;
    x.tag = tag; x.at = at; x.port = port; x.fld = fld; x.exp = e;
    sb.push_back(x);
  endtask

  function automatic logic [31:0] get_fld(input int port, input int fld);
    case (fld)
      F_RST:   return {31'd0, port_rst_n_out[port]};
      F_BLK:   return {31'd0, tx_block[port]};
      F_ACK:   return {31'd0, port_rst_ack[port]};
      F_TO:    return {31'd0, drain_timeout[port]};
      default: return 32'hdead;
    endcase
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard consumer: compare every expectation due at this cycle.
  always begin
    @(posedge clk);
    #1;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      chk($sformatf("%s[p%0d]@%0d", e.tag, e.port, cyc), get_fld(e.port, e.fld), {31'd0, e.exp});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, cyc=%0d expected end", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_n = 4'hF; tvalid = 4'h0; tready = 4'hF; tlast = 4'h0;
    repeat (5) @(negedge clk);

    // Reset values, then power-up release timeline
    t = cyc;
    for (int p = 0; p < 4; p++) begin
      push("por_rst", t + 1, p, F_RST, 1'b0);
      push("por_blk", t + 1, p, F_BLK, 1'b1);
      push("por_ack", t + 1, p, F_ACK, 1'b1);
      push("por_to",  t + 1, p, F_TO,  1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    t = cyc;
    for (int p = 0; p < 4; p++) begin
      push("pu_rst_hold", t + 15, p, F_RST, 1'b0);
      push("pu_ack_hold", t + 15, p, F_ACK, 1'b1);
    end
    for (int p = 0; p < 4; p++) push("pu_ack_rel", t + 16, p, F_ACK, 1'b0);
    for (int p = 0; p < 4; p++) begin
      push("pu_rst_late", t + 20, p, F_RST, 1'b0);
      push("pu_blk_run",  t + 20, p, F_BLK, 1'b0);
    end
    for (int p = 0; p < 4; p++) push("pu_rst_up", t + 21, p, F_RST, 1'b1);
    wait_until(t + 25);

    // Idle port 2 request for 40 cycles
    t = cyc;
    req_n[2] = 1'b0;
    push("idle_blk",  t + 1, 2, F_BLK, 1'b1);
    push("idle_rst1", t + 1, 2, F_RST, 1'b1);
    push("idle_rst0", t + 2, 2, F_RST, 1'b0);
    push("idle_ack",  t + 2, 2, F_ACK, 1'b1);
    push("oth_rst",   t + 2, 0, F_RST, 1'b1);
    push("oth_blk",   t + 2, 0, F_BLK, 1'b0);
    push("idle_ackr", t + 41, 2, F_ACK, 1'b0);
    push("idle_rel0", t + 45, 2, F_RST, 1'b0);
    push("idle_rel1", t + 46, 2, F_RST, 1'b1);
    wait_until(t + 40);
    req_n[2] = 1'b1;
    wait_until(t + 50);

    // Port 0 mid-packet: 3 beats, request, then 5 more beats ending in tlast
    t = cyc;
    push("pkt_blk",    t + 4,  0, F_BLK, 1'b1);
    push("pkt_hold5",  t + 5,  0, F_RST, 1'b1);
    push("pkt_hold10", t + 10, 0, F_RST, 1'b1);
    push("pkt_drop",   t + 11, 0, F_RST, 1'b0);
    push("pkt_ack",    t + 11, 0, F_ACK, 1'b1);
    push("pkt_rel0",   t + 31, 0, F_RST, 1'b0);
    push("pkt_rel1",   t + 32, 0, F_RST, 1'b1);
    tvalid[0] = 1'b1; tlast[0] = 1'b0;
    wait_until(t + 3);
    tvalid[0] = 1'b0; req_n[0] = 1'b0;
    wait_until(t + 6);
    tvalid[0] = 1'b1;
    wait_until(t + 10);
    tlast[0] = 1'b1;
    wait_until(t + 11);
    tvalid[0] = 1'b0; tlast[0] = 1'b0; req_n[0] = 1'b1;
    wait_until(t + 35);

    // Port 1: one-cycle pulse, then re-request during RELEASE
    t = cyc;
    req_n[1] = 1'b0;
    push("pls_rst1",  t + 1,  1, F_RST, 1'b1);
    push("pls_rst0",  t + 2,  1, F_RST, 1'b0);
    push("pls_ack1",  t + 2,  1, F_ACK, 1'b1);
    push("pls_ack17", t + 17, 1, F_ACK, 1'b1);
    push("pls_ack18", t + 18, 1, F_ACK, 1'b0);
    push("pls_rst18", t + 18, 1, F_RST, 1'b0);
    push("pls_ack19", t + 19, 1, F_ACK, 1'b0);
    push("re_ack20",  t + 20, 1, F_ACK, 1'b1);
    push("re_ack35",  t + 35, 1, F_ACK, 1'b1);
    push("re_ack36",  t + 36, 1, F_ACK, 1'b0);
    push("re_rst40",  t + 40, 1, F_RST, 1'b0);
    push("re_rst41",  t + 41, 1, F_RST, 1'b1);
    push("re_blk41",  t + 41, 1, F_BLK, 1'b0);
    wait_until(t + 1);
    req_n[1] = 1'b1;
    wait_until(t + 19);
    req_n[1] = 1'b0;
    wait_until(t + 20);
    req_n[1] = 1'b1;
    wait_until(t + 45);

    // Port 3: packet stalled mid-stream during drain
    t = cyc;
    tvalid[3] = 1'b1; tready[3] = 1'b1; tlast[3] = 1'b0;
`ifdef PG_QUIESCE_TIMEOUT_EN
    push("to_rst65",  t + 65, 3, F_RST, 1'b1);
    push("to_flag65", t + 65, 3, F_TO,  1'b0);
    push("to_rst66",  t + 66, 3, F_RST, 1'b0);
    push("to_flag66", t + 66, 3, F_TO,  1'b1);
    push("to_rel0",   t + 86, 3, F_RST, 1'b0);
    push("to_rel1",   t + 87, 3, F_RST, 1'b1);
    push("to_sticky", t + 87, 3, F_TO,  1'b1);
    wait_until(t + 1);
    tready[3] = 1'b0; req_n[3] = 1'b0;
    wait_until(t + 66);
    tvalid[3] = 1'b0; tready[3] = 1'b1; req_n[3] = 1'b1;
    wait_until(t + 90);
`else
    push("stall_rst66", t + 66,  3, F_RST, 1'b1);
    push("stall_rst80", t + 80,  3, F_RST, 1'b1);
    push("stall_to80",  t + 80,  3, F_TO,  1'b0);
    push("stall_rst81", t + 81,  3, F_RST, 1'b0);
    push("stall_rel0",  t + 101, 3, F_RST, 1'b0);
    push("stall_rel1",  t + 102, 3, F_RST, 1'b1);
    push("stall_to",    t + 102, 3, F_TO,  1'b0);
    wait_until(t + 1);
    tready[3] = 1'b0; req_n[3] = 1'b0;
    wait_until(t + 80);
    tready[3] = 1'b1; tlast[3] = 1'b1;
    wait_until(t + 81);
    tvalid[3] = 1'b0; tlast[3] = 1'b0; req_n[3] = 1'b1;
    wait_until(t + 105);
`endif

    // Asynchronous reset while port 1 drains an open packet
    t = cyc;
    tvalid[1] = 1'b1; tlast[1] = 1'b0;
    wait_until(t + 1);
    tvalid[1] = 1'b0; req_n[1] = 1'b0;
    wait_until(t + 4);
    chk("drain_rst_hi", {31'd0, port_rst_n_out[1]}, 32'd1);
    chk("drain_blk",    {31'd0, tx_block[1]},       32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {28'd0, port_rst_n_out}, 32'h0);
    chk("async_blk", {28'd0, tx_block},       32'hF);
    chk("async_ack", {28'd0, port_rst_ack},   32'hF);
    chk("async_to",  {28'd0, drain_timeout},  32'h0);
    req_n[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    t = cyc;
    for (int p = 0; p < 4; p++) push("rerun_up", t + 21, p, F_RST, 1'b1);
    wait_until(t + 22);

    // in_pkt was cleared by reset: port 1 drains immediately
    t = cyc;
    req_n[1] = 1'b0;
    push("clr_rst0", t + 2,  1, F_RST, 1'b0);
    push("clr_ack",  t + 2,  1, F_ACK, 1'b1);
    push("clr_rst1", t + 23, 1, F_RST, 1'b1);
    wait_until(t + 3);
    req_n[1] = 1'b1;
    wait_until(t + 26);

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pg_port_rst_quiesce.md
Name: pg_port_rst_quiesce

Overview:
- Per-port reset sequencer for the port gasket. It replaces the fixed 4-flop port reset pipeline with a parametrised, packet-aware sequence.
- On a port reset request it blocks new TX packet starts, waits for the in-flight packet to finish (drain), then asserts port reset for a minimum hold time. After the request is removed, it releases reset through a programmable number of stages.
- One instance covers all flattened ports (links × ports). It sits between the port reset controller and the PF/VF MUX / AFU port connections.

Parameters:
- NUM_PORTS, 4, number of flattened ports handled (one independent FSM each).
- RST_HOLD_CYCLES, 16, minimum cycles port_rst_n_out stays low once asserted; must be ≥1.
- RST_PIPE_DEPTH, 4, cycles from release decision to port_rst_n_out high; must be ≥1.
- DRAIN_TIMEOUT, 4096, maximum DRAIN cycles before forced reset; used only when PG_QUIESCE_TIMEOUT_EN is defined; must be ≥1.

Ports:
- clk  in  1  port gasket clock.
- rst_n  in  1  global reset, asynchronous, active-low.
- port_rst_req_n  in  NUM_PORTS  per-port reset request, active-low, synchronous to clk.
- tx_tvalid  in  NUM_PORTS  observed AFU TX A tvalid per port.
- tx_tready  in  NUM_PORTS  observed AFU TX A tready per port.
- tx_tlast  in  NUM_PORTS  observed AFU TX A tlast per port.
- tx_block  out  NUM_PORTS  1 = upstream must not start a new packet; beats of the current packet may continue.
- port_rst_n_out  out  NUM_PORTS  sequenced port reset, active-low, registered.
- port_rst_ack  out  NUM_PORTS  1 while the port is held in reset (ASSERT state).
- drain_timeout  out  NUM_PORTS  sticky flag: the drain was forced by timeout.

Behaviour:
- Reset values (rst_n=0, asynchronous): state=ASSERT, hold counter=RST_HOLD_CYCLES-1, in_pkt=0, port_rst_n_out=0, tx_block=1, port_rst_ack=1, drain_timeout=0.
- Ports are fully independent and there is no cross-port arbitration.
- All outputs are registered and decoded from next-state.
- Definitions:
  - beat = tx_tvalid & tx_tready.
  - in_pkt register: set on beat & !tlast; cleared on beat & tlast.
  - in_pkt_nx = value of in_pkt after the current cycle.
- RUN: tx_block=0, port_rst_n_out=1, ack=0.
  - If req_n=0, go to DRAIN. tx_block=1 from the next cycle.
  - A beat accepted in the transition cycle is tracked by in_pkt.
- DRAIN: tx_block=1, port_rst_n_out=1.
  - When in_pkt_nx=0, go to ASSERT and load the hold counter with RST_HOLD_CYCLES-1.
  - A packet start while tx_block=1 is an upstream violation. It is still tracked, so reset never cuts a packet mid-stream.
  - req_n returning to 1 during DRAIN does not abort; the sequence is committed.
- ASSERT: port_rst_n_out=0, ack=1, tx_block=1. The counter decrements to 0 and then saturates.
  - When counter=0 and req_n=1, go to RELEASE and load the counter with RST_PIPE_DEPTH-1.
  - Minimum low time is exactly RST_HOLD_CYCLES cycles.
- RELEASE: port_rst_n_out=0, ack=0, tx_block=1.
  - The counter decrements. At 0, go to RUN; port_rst_n_out=1 on the following cycle.
  - If req_n=0 during RELEASE, go to ASSERT and reload the hold counter.
- Latency:
  - Idle port, req_n falls at cycle t → port_rst_n_out=0 at t+2 (t+1 enters DRAIN, drains immediately).
  - After hold with req_n=1 → port_rst_n_out=1 exactly RST_PIPE_DEPTH+1 cycles after entering RELEASE.
- Counter width: $clog2(max(RST_HOLD_CYCLES, RST_PIPE_DEPTH, DRAIN_TIMEOUT)+1). Counters never wrap.
- rst_n asserted mid-operation aborts any state immediately to the reset values. in_pkt is cleared.

Optional Feature:
- Macro: PG_QUIESCE_TIMEOUT_EN.
- Defined:
  - A per-port drain counter starts at entry to DRAIN.
  - After DRAIN_TIMEOUT cycles with in_pkt_nx still 1, the port is forced to ASSERT, in_pkt is cleared, and drain_timeout[p] is set.
  - drain_timeout[p] is cleared only by rst_n.
- Not defined: DRAIN waits indefinitely, drain_timeout is tied to 0, and no counter logic is built.

Decomposition:
- pg_port_quiesce_pkg holds:
  - t_quiesce_state enum: RUN, DRAIN, ASSERT, RELEASE.
  - Default constants for hold, pipe depth and timeout.
  - A counter-width function.
- Sub-module pg_port_quiesce_fsm: a single-port FSM with in_pkt tracking and counters. The top instantiates NUM_PORTS copies in a generate loop.

Test Plan:
- Power-up: rst_n low 5 cycles, then high, req_n=all 1, defaults → port_rst_n_out rises 16+4+1 cycles after rst_n deassert; ack high only during hold.
- Idle port 2, req_n[2] low at t=100 for 40 cycles → port_rst_n_out[2]=0 at t=102, tx_block[2]=1 at t=101; other ports unaffected.
- Port 0 mid-packet (3 of 8 beats sent), req_n[0] low → reset held off until the cycle after the tlast beat; no port_rst_n_out[0] drop before tlast.
- req_n pulsed low 1 cycle → port still held low exactly 16 cycles, then 4-cycle release; req_n re-low during RELEASE → returns to ASSERT with a full 16-cycle hold.
- With PG_QUIESCE_TIMEOUT_EN, DRAIN_TIMEOUT=64, packet stalled (tready=0) → forced ASSERT at cycle 64 of DRAIN, drain_timeout=1 and sticky after release.
- rst_n asserted while port 1 is in DRAIN → all outputs at reset values in the same cycle, asynchronously.
